// File: rtl/window_accumulator_pkg.sv
// rtl/window_accumulator_pkg.sv - shared types for the window accumulator
package window_accumulator_pkg;

  // Occupancy of the one-entry result register
  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

endpackage : window_accumulator_pkg

// File: rtl/window_accumulator_sat_add.sv
// rtl/window_accumulator_sat_add.sv - combinational unsigned saturating adder
module sat_add #(
  parameter int ACC_WIDTH  = 20,
  parameter int DATA_WIDTH = 17
) (
  input  logic [ACC_WIDTH-1:0]  a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic [ACC_WIDTH-1:0]  sum_o,
  output logic                  sat_o
);

  logic [ACC_WIDTH:0] full_sum;

  // One extra bit catches the carry; on carry the result clamps to all ones
  always_comb begin
    full_sum = {1'b0, a_i} + (ACC_WIDTH + 1)'(b_i);
    sat_o    = full_sum[ACC_WIDTH];
    sum_o    = sat_o ? {ACC_WIDTH{1'b1}} : full_sum[ACC_WIDTH-1:0];
  end

endmodule : sat_add

// File: rtl/window_accumulator.sv
// rtl/window_accumulator.sv - saturating windowed sum with one-entry valid/ready output
module window_accumulator
  import window_accumulator_pkg::*;
#(
  parameter int DATA_WIDTH = 17,
  parameter int ACC_LEN    = 8,
  parameter int ACC_WIDTH  = 20
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en_i,
  input  logic [DATA_WIDTH-1:0]      data_i,
  input  logic                       clr_i,
  output logic [ACC_WIDTH-1:0]       data_o,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic                       ovf_o,
  output logic                       ovr_o,
  output logic [$clog2(ACC_LEN)-1:0] cnt_o
);

  localparam int CNT_WIDTH = $clog2(ACC_LEN);
  localparam int LAST      = ACC_LEN - 1;
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(LAST);

  logic [ACC_WIDTH-1:0] acc_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 wovf_q;
  logic [ACC_WIDTH-1:0] data_q;
  logic                 ovf_q;
  logic                 ovr_q;
  out_state_e           state_q, state_d;

  logic [ACC_WIDTH-1:0] sum;
  logic                 sat;
  logic                 complete;
  logic                 final_ovf;
  logic                 load;
  logic                 drop;

  sat_add #(
    .ACC_WIDTH  (ACC_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_sat_add (
    .a_i   (acc_q),
    .b_i   (data_i),
    .sum_o (sum),
    .sat_o (sat)
  );

  assign complete  = en_i && (cnt_q == LAST_CNT);
  assign final_ovf = wovf_q | sat;

  // Window accumulation: clear wins, completion restarts the window with no bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      wovf_q <= 1'b0;
    end else if (clr_i) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      wovf_q <= 1'b0;
    end else if (en_i) begin
      if (complete) begin
        acc_q  <= '0;
        cnt_q  <= '0;
        wovf_q <= 1'b0;
      end else begin
        acc_q  <= sum;
        cnt_q  <= cnt_q + CNT_WIDTH'(1);
        wovf_q <= final_ovf;
      end
    end
  end

  // Output register occupancy state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= OUT_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next occupancy plus load/drop decisions; a consume frees the slot for a same-cycle completion
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    drop    = 1'b0;
    if (clr_i) begin
      state_d = OUT_EMPTY;
    end else begin
      case (state_q)
        OUT_EMPTY: begin
          if (complete) begin
            load    = 1'b1;
            state_d = OUT_FULL;
          end
        end
        OUT_FULL: begin
          if (complete) begin
            if (ready_i) begin
              load = 1'b1;
            end else begin
              drop = 1'b1;
            end
          end else if (ready_i) begin
            state_d = OUT_EMPTY;
          end
        end
        default: state_d = OUT_EMPTY;
      endcase
    end
  end

  // Result payload and flags; data holds its last value once consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      ovf_q  <= 1'b0;
      ovr_q  <= 1'b0;
    end else if (clr_i) begin
      ovf_q  <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      if (load) begin
        data_q <= sum;
        ovf_q  <= final_ovf;
      end
      if (drop) begin
        ovr_q <= 1'b1;
      end
    end
  end

  assign data_o  = data_q;
  assign valid_o = (state_q == OUT_FULL);
  assign ovf_o   = ovf_q;
  assign ovr_o   = ovr_q;
  assign cnt_o   = cnt_q;

endmodule : window_accumulator

// File: tb/tb_window_accumulator.sv
// tb/tb_window_accumulator.sv - randomized self-checking bench for window_accumulator
module tb_window_accumulator;

  localparam int DW   = 17;
  localparam int AL   = 8;
  localparam int AW   = 18;
  localparam int CW   = $clog2(AL);
  localparam longint AMAX = (longint'(1) << AW) - 1;

  logic          clk;
  logic          rst_n;
  logic          en_i;
  logic [DW-1:0] data_i;
  logic          clr_i;
  logic [AW-1:0] data_o;
  logic          valid_o;
  logic          ready_i;
  logic          ovf_o;
  logic          ovr_o;
  logic [CW-1:0] cnt_o;

  int total;
  int bad;

  // Reference model: samples of the open window, and the result slot contents
  longint        win_q[$];
  logic [AW-1:0] m_data;
  logic          m_valid;
  logic          m_ovf;
  logic          m_ovr;

  window_accumulator #(
    .DATA_WIDTH (DW),
    .ACC_LEN    (AL),
    .ACC_WIDTH  (AW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (en_i),
    .data_i  (data_i),
    .clr_i   (clr_i),
    .data_o  (data_o),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .ovf_o   (ovf_o),
    .ovr_o   (ovr_o),
    .cnt_o   (cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    win_q.delete();
    m_data  = '0;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_ovr   = 1'b0;
  endtask

  // Drive one cycle and advance the model from the window rules
  task automatic cyc(input logic en, input logic [DW-1:0] d, input logic clr, input logic rdy);
    longint tot;
    logic   consume;
    en_i    = en;
    data_i  = d;
    clr_i   = clr;
    ready_i = rdy;
    @(posedge clk);
    consume = m_valid && rdy;
    if (clr) begin
      win_q.delete();
      m_valid = 1'b0;
      m_ovf   = 1'b0;
      m_ovr   = 1'b0;
    end else if (en && win_q.size() == AL - 1) begin
      win_q.push_back(longint'(d));
      tot = 0;
      foreach (win_q[k]) tot += win_q[k];
      win_q.delete();
      if (!m_valid || consume) begin
        m_valid = 1'b1;
        m_data  = (tot > AMAX) ? AW'(AMAX) : AW'(tot);
        m_ovf   = (tot > AMAX);
      end else begin
        m_ovr = 1'b1;
      end
    end else begin
      if (en) win_q.push_back(longint'(d));
      if (consume) m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc(1'b0, '0, 1'b0, 1'b0);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) cyc(1'b1, DW'($urandom_range(1, 1000)), 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    total++;
    if ({data_o, valid_o, ovf_o, ovr_o, cnt_o} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got data=%h valid=%b ovf=%b ovr=%b cnt=%0d want all zero",
               data_o, valid_o, ovf_o, ovr_o, cnt_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < AL; i++) cyc(1'b1, DW'($urandom_range(1, 1000)), 1'b0, 1'b1);
    total++;
    if (valid_o !== 1'b1 || data_o !== m_data) begin
      bad++;
      $display("FAIL reset_next_window: got valid=%b data=%h want valid=1 data=%h", valid_o, data_o, m_data);
    end
    cyc(1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_basic();
    for (int i = 0; i < AL; i++) cyc(1'b1, 17'h7526, 1'b0, 1'b1);
    total++;
    if (valid_o !== 1'b1 || data_o !== 18'h3A930 || ovf_o !== 1'b0) begin
      bad++;
      $display("FAIL basic_sum: got valid=%b data=%h ovf=%b want 1 3a930 0", valid_o, data_o, ovf_o);
    end
    cyc(1'b0, '0, 1'b0, 1'b1);
    total++;
    if (valid_o !== 1'b0) begin
      bad++;
      $display("FAIL basic_one_cycle: got valid=%b want 0", valid_o);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < AL; i++) cyc(1'b1, 17'h1FFFF, 1'b0, 1'b1);
    total++;
    if (data_o !== 18'h3FFFF || ovf_o !== 1'b1 || valid_o !== 1'b1) begin
      bad++;
      $display("FAIL sat_clamp: got data=%h ovf=%b valid=%b want 3ffff 1 1", data_o, ovf_o, valid_o);
    end
    for (int i = 0; i < AL; i++) cyc(1'b1, 17'h1, 1'b0, 1'b1);
    total++;
    if (data_o !== 18'h8 || ovf_o !== 1'b0 || valid_o !== 1'b1) begin
      bad++;
      $display("FAIL sat_next_window: got data=%h ovf=%b valid=%b want 8 0 1", data_o, ovf_o, valid_o);
    end
    cyc(1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_overrun();
    cyc(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < AL; i++) cyc(1'b1, 17'h1, 1'b0, 1'b0);
    for (int i = 0; i < AL; i++) cyc(1'b1, DW'($urandom_range(2, 500)), 1'b0, 1'b0);
    total++;
    if (data_o !== 18'h8 || valid_o !== 1'b1 || ovr_o !== 1'b1) begin
      bad++;
      $display("FAIL overrun_drop: got data=%h valid=%b ovr=%b want 8 1 1", data_o, valid_o, ovr_o);
    end
    cyc(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < AL; i++) cyc(1'b1, 17'h1, 1'b0, 1'b0);
    for (int i = 0; i < AL; i++) cyc(1'b1, DW'(i + 3), 1'b0, (i == AL - 1));
    total++;
    if (data_o !== 18'd52 || valid_o !== 1'b1 || ovr_o !== 1'b0) begin
      bad++;
      $display("FAIL overrun_consume: got data=%h valid=%b ovr=%b want 34 1 0", data_o, valid_o, ovr_o);
    end
    cyc(1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_clear();
    for (int i = 0; i < AL - 1; i++) cyc(1'b1, DW'($urandom_range(1, 100)), 1'b0, 1'b1);
    cyc(1'b1, 17'h55, 1'b1, 1'b1);
    total++;
    if (valid_o !== 1'b0 || cnt_o !== '0) begin
      bad++;
      $display("FAIL clear_priority: got valid=%b cnt=%0d want 0 0", valid_o, cnt_o);
    end
    for (int i = 0; i < AL; i++) cyc(1'b1, DW'(10 * (i + 1)), 1'b0, 1'b1);
    total++;
    if (valid_o !== 1'b1 || data_o !== 18'd360) begin
      bad++;
      $display("FAIL clear_fresh_window: got valid=%b data=%h want 1 168", valid_o, data_o);
    end
    cyc(1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_gapped();
    int n;
    n = 0;
    while (n < AL) begin
      if ($urandom_range(0, 2) == 0) begin
        cyc(1'b0, DW'($urandom), 1'b0, 1'b1);
      end else begin
        n++;
        cyc(1'b1, DW'(n), 1'b0, 1'b1);
      end
      total++;
      if (cnt_o !== CW'(n % AL)) begin
        bad++;
        $display("FAIL gapped_cnt: got cnt=%0d want %0d", cnt_o, n % AL);
      end
    end
    total++;
    if (valid_o !== 1'b1 || data_o !== 18'h24) begin
      bad++;
      $display("FAIL gapped_sum: got valid=%b data=%h want 1 24", valid_o, data_o);
    end
    cyc(1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    logic [DW-1:0] d;
    for (int i = 0; i < 400; i++) begin
      d = ($urandom_range(0, 3) == 0) ? DW'($urandom) : DW'($urandom_range(0, 4000));
      cyc($urandom_range(0, 3) != 0, d, $urandom_range(0, 60) == 0, $urandom_range(0, 9) < 3);
      total++;
      if (valid_o !== m_valid || cnt_o !== CW'(win_q.size()) || ovr_o !== m_ovr) begin
        bad++;
        $display("FAIL random_ctrl cyc%0d: got valid=%b cnt=%0d ovr=%b want %b %0d %b",
                 i, valid_o, cnt_o, ovr_o, m_valid, win_q.size(), m_ovr);
      end
      if (m_valid) begin
        total++;
        if (data_o !== m_data || ovf_o !== m_ovf) begin
          bad++;
          $display("FAIL random_data cyc%0d: got data=%h ovf=%b want %h %b", i, data_o, ovf_o, m_data, m_ovf);
        end
      end
    end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rst_n   = 1'b0;
    en_i    = 1'b0;
    data_i  = '0;
    clr_i   = 1'b0;
    ready_i = 1'b0;
    model_reset();
    test_reset();
    test_basic();
    test_saturation();
    test_overrun();
    test_clear();
    test_gapped();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_window_accumulator
